// File: rtl/spi_regs_pkg.sv
// Shared definitions for the register-mapped SPI slave.
// Holds the CPU register offsets, the status bit positions, the frame width,
// the transfer state type and a helper that assembles the status word.
package spi_regs_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int ROE_BIT  = 3;
  localparam int TOE_BIT  = 4;
  localparam int TMT_BIT  = 5;
  localparam int TRDY_BIT = 6;
  localparam int RRDY_BIT = 7;
  localparam int E_BIT    = 8;

  localparam int FRAME_BITS = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_state_e;

  // Status word with every bit outside [8:3] forced to zero; E is the OR of
  // the two overrun flags.
  function automatic logic [15:0] pack_status(input logic roe, input logic toe,
                                              input logic tmt, input logic trdy,
                                              input logic rrdy);
    logic [15:0] s;
    s           = '0;
    s[ROE_BIT]  = roe;
    s[TOE_BIT]  = toe;
    s[TMT_BIT]  = tmt;
    s[TRDY_BIT] = trdy;
    s[RRDY_BIT] = rrdy;
    s[E_BIT]    = roe | toe;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with an edge register for one asynchronous pin.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   async_in     : raw pin
//   level        : synchronized level, time-aligned with the edge pulses
//   rise, fall   : one-clk registered pulses on a synchronized edge
// The pin-to-pulse path is three flops, so an edge is acted upon by the
// consumer on the fourth clk after it appears at the pin.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic edge_q;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = sync_q & ~edge_q;
    fall_d = ~sync_q & edge_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      edge_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      edge_q <= sync_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = edge_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_regs.sv
// Register-mapped SPI mode-0 slave, 8-bit frames, MSB first.
// Ports:
//   clk, reset_n          : system clock, asynchronous active-low reset
//   mem_addr              : register select (0 rxdata, 1 txdata, 2 status, 3 control)
//   read_n, write_n       : active-low one-clk access strobes
//   data_from_cpu         : write data, bits [8:0] used
//   data_to_cpu           : registered read data
//   dataavailable         : status.RRDY
//   readyfordata          : status.TRDY
//   irq                   : registered OR of enabled status bits
//   SCLK, MOSI, SS_n      : SPI pins from the external master
//   MISO                  : shift register MSB while selected, else 0
// A single shift register serves both directions: MOSI bits are captured on
// SCLK rise and moved in on the following fall, which is also when the next
// transmit bit reaches the MSB.
module spi_slave_regs
  import spi_regs_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        irq,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .async_in(SCLK),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .async_in(SS_n),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .async_in(MOSI),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        mosi_bit_q, mosi_bit_d;
  logic [7:0]  rxdata_q, rxdata_d;
  logic [7:0]  holding_q, holding_d;
  logic        trdy_q, trdy_d;
  logic        rrdy_q, rrdy_d;
  logic        roe_q, roe_d;
  logic        toe_q, toe_d;
  logic [5:0]  control_q, control_d;
  logic [15:0] data_to_cpu_q, data_to_cpu_d;
  logic        irq_q, irq_d;

  logic [15:0] status_w;
  logic        rd, wr, rx_read, load_tx;

  logic unused_ok;
  assign unused_ok = ^{data_from_cpu[15:9], data_from_cpu[2:0],
                       sclk_level, ss_level, mosi_rise, mosi_fall};

  // TMT only reflects the holding register while deselected; during a frame
  // the shift register is considered occupied.
  assign status_w = pack_status(roe_q, toe_q, trdy_q && (state_q == IDLE),
                                trdy_q, rrdy_q);

  assign rd      = ~read_n;
  assign wr      = ~write_n;
  assign rx_read = rd && (mem_addr == ADDR_RXDATA);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    mosi_bit_d    = mosi_bit_q;
    rxdata_d      = rxdata_q;
    holding_d     = holding_q;
    trdy_d        = trdy_q;
    rrdy_d        = rrdy_q;
    roe_d         = roe_q;
    toe_d         = toe_q;
    control_d     = control_q;
    data_to_cpu_d = data_to_cpu_q;
    load_tx       = 1'b0;

    if (rd) begin
      case (mem_addr)
        ADDR_RXDATA: begin
          data_to_cpu_d = {8'h00, rxdata_q};
          rrdy_d        = 1'b0;
        end
        ADDR_TXDATA:  data_to_cpu_d = {8'h00, holding_q};
        ADDR_STATUS:  data_to_cpu_d = status_w;
        ADDR_CONTROL: data_to_cpu_d = {7'b0, control_q, 3'b0};
        default:      data_to_cpu_d = '0;
      endcase
    end

    if (wr) begin
      case (mem_addr)
        ADDR_TXDATA: begin
          if (trdy_q) begin
            holding_d = data_from_cpu[7:0];
            trdy_d    = 1'b0;
          end else begin
            toe_d = 1'b1;
          end
        end
        ADDR_STATUS: begin
          roe_d = 1'b0;
          toe_d = 1'b0;
        end
        ADDR_CONTROL: control_d = data_from_cpu[8:3];
        default: ;
      endcase
    end

    // Overrun setting comes after the status-write clear so a simultaneous
    // overrun survives; a same-clk rxdata read keeps RRDY set without ROE.
    if (ss_fall) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
      load_tx   = 1'b1;
    end else if (ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (state_q == SHIFT) begin
      if (sclk_rise) begin
        mosi_bit_d = mosi_level;
        if (bit_cnt_q == LAST_BIT) begin
          rxdata_d  = {shift_q[6:0], mosi_level};
          rrdy_d    = 1'b1;
          if (rrdy_q && !rx_read) roe_d = 1'b1;
          bit_cnt_d = '0;
          load_tx   = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
        // A zero count means the shift register was just (re)loaded, so its
        // MSB is already the bit to present.
        shift_d = {shift_q[6:0], mosi_bit_q};
      end
    end

    // Loads look at the registered TRDY, so a txdata write landing in the
    // same clk is not seen here and the frame underruns with 8'h00.
    if (load_tx) begin
      if (!trdy_q) begin
        shift_d = holding_q;
        trdy_d  = 1'b1;
      end else begin
        shift_d = '0;
      end
    end
  end

  assign irq_d = |(status_w[E_BIT:ROE_BIT] & control_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      mosi_bit_q    <= 1'b0;
      rxdata_q      <= '0;
      holding_q     <= '0;
      trdy_q        <= 1'b1;
      rrdy_q        <= 1'b0;
      roe_q         <= 1'b0;
      toe_q         <= 1'b0;
      control_q     <= '0;
      data_to_cpu_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      mosi_bit_q    <= mosi_bit_d;
      rxdata_q      <= rxdata_d;
      holding_q     <= holding_d;
      trdy_q        <= trdy_d;
      rrdy_q        <= rrdy_d;
      roe_q         <= roe_d;
      toe_q         <= toe_d;
      control_q     <= control_d;
      data_to_cpu_q <= data_to_cpu_d;
      irq_q         <= irq_d;
    end
  end

  assign data_to_cpu   = data_to_cpu_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = trdy_q;
  assign MISO          = (state_q == SHIFT) ? shift_q[7] : 1'b0;

endmodule
